// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared trap request codes, cause codes and FSM states for pc_gen
package pc_gen_pkg;

  localparam logic [1:0] E_CALL       = 2'd1;
  localparam logic [1:0] E_BREAK      = 2'd2;
  localparam logic [1:0] MEM_MISALIGN = 2'd3;

  localparam logic [2:0] CAUSE_BR_MISALIGN  = 3'd0;
  localparam logic [2:0] CAUSE_ECALL        = 3'd1;
  localparam logic [2:0] CAUSE_EBREAK       = 3'd2;
  localparam logic [2:0] CAUSE_MEM_MISALIGN = 3'd3;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HANDLER = 2'd1,
    S_HALT    = 2'd2
  } pc_state_e;

  // Trap request codes line up with the low bits of the cause codes.
  function automatic logic [2:0] req_to_cause(input logic [1:0] req);
    return {1'b0, req};
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// rtl/carry_lookahead_adder.sv - W-bit generate/propagate adder, carry-out dropped (wraps modulo 2^W)
module carry_lookahead_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] g;
  logic [W-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic cy;
    cy  = cin;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = p[i] ^ cy;
      cy     = g[i] | (p[i] & cy);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator: sequential step, branch redirect, trap vectoring and return
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter logic [XLEN-1:0]  TRAP_BASE = 'h800,
  parameter bit               VECTORED  = 1'b1,
  parameter int               IALIGN    = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_is_branch_true,
  input  logic [XLEN-1:0] i_branch_addr,
  input  logic [1:0]      i_trap,
  input  logic            i_mret,
  output logic [XLEN-1:0] o_r_pc,
  output logic            o_trap_taken,
  output logic [2:0]      o_cause,
  output logic [XLEN-1:0] o_epc,
  output logic [XLEN-1:0] o_tval,
  output logic            o_in_handler,
  output logic            o_halted
);

  localparam logic [XLEN-1:0] INC = XLEN'(IALIGN / 8);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_inc, pc_d, epc_d, tval_d, vector;
  logic [2:0]      cause_d, trap_cause;
  logic            taken_d, misalign, trap_evt;

  carry_lookahead_adder #(.W(XLEN)) u_inc (
    .a   (o_r_pc),
    .b   (INC),
    .cin (1'b0),
    .sum (pc_inc)
  );

  assign misalign   = i_is_branch_true &
                      ((IALIGN == 32) ? (|i_branch_addr[1:0]) : i_branch_addr[0]);
  assign trap_evt   = misalign | (i_trap != 2'b00);
  assign trap_cause = misalign ? CAUSE_BR_MISALIGN : req_to_cause(i_trap);
  assign vector     = VECTORED ? (TRAP_BASE + {{(XLEN-5){1'b0}}, trap_cause, 2'b00})
                               : TRAP_BASE;

  always_comb begin
    state_d = state_q;
    pc_d    = o_r_pc;
    epc_d   = o_epc;
    cause_d = o_cause;
    tval_d  = o_tval;
    taken_d = 1'b0;
    case (state_q)
      S_RUN, S_HANDLER: begin
        if (trap_evt) begin
          // A trap raised while already in the handler is a double fault.
          if (state_q == S_HANDLER) begin
            state_d = S_HALT;
          end else begin
            state_d = S_HANDLER;
            pc_d    = vector;
            epc_d   = o_r_pc;
            cause_d = trap_cause;
            tval_d  = misalign ? i_branch_addr : '0;
            taken_d = 1'b1;
          end
        end else if (i_mret && (state_q == S_HANDLER)) begin
          state_d = S_RUN;
          pc_d    = o_epc;
        end else if (i_is_branch_true) begin
          pc_d = i_branch_addr;
        end else if (!i_stall) begin
          pc_d = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_RUN;
      o_r_pc       <= RESET_VEC;
      o_epc        <= '0;
      o_tval       <= '0;
      o_cause      <= '0;
      o_trap_taken <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_r_pc       <= pc_d;
      o_epc        <= epc_d;
      o_tval       <= tval_d;
      o_cause      <= cause_d;
      o_trap_taken <= taken_d;
    end
  end

  assign o_in_handler = (state_q == S_HANDLER);
  assign o_halted     = (state_q == S_HALT);

endmodule
